// File: rtl/bbus_dma_if.sv
// A-bus / B-bus signal bundle shared by the bbus_dma engine and the bus model.
interface bbus_dma_if;
    logic [23:0] CA;
    logic        CPURD_N;
    logic        CPUWR_N;
    logic [7:0]  PA;
    logic        PARD_N;
    logic        PAWR_N;
    logic [7:0]  A_DI;
    logic [7:0]  B_DI;
    logic [7:0]  D_OUT;

    modport master (
        output CA, CPURD_N, CPUWR_N, PA, PARD_N, PAWR_N, D_OUT,
        input  A_DI, B_DI
    );

    modport slave (
        input  CA, CPURD_N, CPUWR_N, PA, PARD_N, PAWR_N, D_OUT,
        output A_DI, B_DI
    );
endinterface

// File: rtl/bbus_dma.sv
// Single-channel A-bus <-> B-bus DMA engine clocked by SYSCLK_CE bus cycles.
// Optional BBUS_DMA_WRAM_GUARD_EN suppresses the write strobe for PA=80 with a WRAM CA.
module bbus_dma (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SYSCLK_CE,
    input  logic        CFG_WE,
    input  logic [2:0]  CFG_A,
    input  logic [7:0]  CFG_D,
    input  logic        START,
    bbus_dma_if.master  bus,
    output logic        BUSY,
    output logic        DONE
);
    // state  | meaning
    // IDLE   | waiting; a latched START moves to SETUP on the next CE edge
    // SETUP  | one CE period, strobes high
    // XFER   | one byte per CE period
    // FINISH | one CE period, strobes high, then DONE
    typedef enum logic [1:0] {IDLE, SETUP, XFER, FINISH} state_t;

    state_t      state;
    logic        pending;
    logic [7:0]  dmap;
    logic [7:0]  bbad;
    logic [15:0] a1t;
    logic [7:0]  a1b;
    logic [15:0] das;
    logic [1:0]  idx;

    logic [2:0]  mode_eff;
    logic [1:0]  idx_mask;
    logic [1:0]  idx_next;
    logic [1:0]  byte_idx;
    logic [15:0] a1t_step;
    logic [15:0] byte_a1t;
    logic [7:0]  byte_off;
    logic [7:0]  byte_pa;
    logic        byte_guard;

    // Everything below describes the byte that the next CE edge puts on the bus.
    always_comb begin
        mode_eff = (dmap[2:0] > 3'd4) ? (dmap[2:0] - 3'd4) : dmap[2:0];
        case (mode_eff)
            3'd0:       idx_mask = 2'd0;
            3'd1, 3'd2: idx_mask = 2'd1;
            default:    idx_mask = 2'd3;
        endcase
        idx_next = (idx + 2'd1) & idx_mask;
        a1t_step = dmap[3] ? a1t : (dmap[4] ? (a1t - 16'd1) : (a1t + 16'd1));
        byte_a1t = (state == XFER) ? a1t_step : a1t;
        byte_idx = (state == XFER) ? idx_next : 2'd0;
        case (mode_eff)
            3'd1:    byte_off = {7'd0, byte_idx[0]};
            3'd3:    byte_off = {7'd0, byte_idx[1]};
            3'd4:    byte_off = {6'd0, byte_idx};
            default: byte_off = 8'd0;
        endcase
        byte_pa = bbad + byte_off;
`ifdef BBUS_DMA_WRAM_GUARD_EN
        byte_guard = (byte_pa == 8'h80) &&
                     ((a1b[7:1] == 7'h3F) || (!a1b[6] && (byte_a1t[15:13] == 3'd0)));
`else
        byte_guard = 1'b0;
`endif
    end

    assign bus.D_OUT = (state == XFER) ? (dmap[7] ? bus.B_DI : bus.A_DI) : 8'h00;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            pending     <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            dmap        <= 8'd0;
            bbad        <= 8'd0;
            a1t         <= 16'd0;
            a1b         <= 8'd0;
            das         <= 16'd0;
            idx         <= 2'd0;
            bus.CA      <= 24'd0;
            bus.PA      <= 8'hFF;
            bus.CPURD_N <= 1'b1;
            bus.CPUWR_N <= 1'b1;
            bus.PARD_N  <= 1'b1;
            bus.PAWR_N  <= 1'b1;
        end else begin
            DONE <= 1'b0;
            if (CFG_WE && !BUSY) begin
                case (CFG_A)
                    3'd0:    dmap      <= CFG_D;
                    3'd1:    bbad      <= CFG_D;
                    3'd2:    a1t[7:0]  <= CFG_D;
                    3'd3:    a1t[15:8] <= CFG_D;
                    3'd4:    a1b       <= CFG_D;
                    3'd5:    das[7:0]  <= CFG_D;
                    3'd6:    das[15:8] <= CFG_D;
                    default: ;
                endcase
            end
            if (START && !BUSY) begin
                pending <= 1'b1;
                BUSY    <= 1'b1;
            end
            if (SYSCLK_CE) begin
                case (state)
                    IDLE: begin
                        if (pending) begin
                            pending <= 1'b0;
                            state   <= SETUP;
                        end
                    end
                    SETUP, XFER: begin
                        if (state == XFER) begin
                            a1t <= a1t_step;
                            das <= das - 16'd1;
                            idx <= idx_next;
                        end else begin
                            idx <= 2'd0;
                        end
                        // DAS of 0 at start wraps through FFFF, giving 65536 bytes.
                        if (state == XFER && das == 16'd1) begin
                            state       <= FINISH;
                            bus.PA      <= 8'hFF;
                            bus.CPURD_N <= 1'b1;
                            bus.CPUWR_N <= 1'b1;
                            bus.PARD_N  <= 1'b1;
                            bus.PAWR_N  <= 1'b1;
                        end else begin
                            state       <= XFER;
                            bus.CA      <= {a1b, byte_a1t};
                            bus.PA      <= byte_pa;
                            bus.CPURD_N <= dmap[7];
                            bus.PAWR_N  <= dmap[7] | byte_guard;
                            bus.PARD_N  <= !dmap[7];
                            bus.CPUWR_N <= !dmap[7] | byte_guard;
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bbus_dma.sv
// Directed self-checking bench for bbus_dma; CE runs one CLK in three.
module tb_bbus_dma;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ce = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_a = 3'd0;
    logic [7:0] cfg_d = 8'd0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_mis = 0;

    logic [23:0] ca_log [0:15];
    logic [7:0]  pa_log [0:15];
    logic [7:0]  exp_pa [0:15];
    int n_bytes, n_cpurd, n_cpuwr, n_pard, n_pawr, n_data_bad, n_done, gap;
    bit got_done;

    bbus_dma_if bus();

    bbus_dma dut (
        .CLK(clk), .RST_N(rst_n), .SYSCLK_CE(ce),
        .CFG_WE(cfg_we), .CFG_A(cfg_a), .CFG_D(cfg_d), .START(start),
        .bus(bus), .BUSY(busy), .DONE(done)
    );

    always #5 clk = ~clk;

    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            k = (k == 2) ? 0 : k + 1;
            ce = (k == 2);
        end
    end

    task automatic cfg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_a = a; cfg_d = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic setup_xfer(input logic [7:0] dm, input logic [7:0] bb, input logic [7:0] ab,
                              input logic [15:0] at, input logic [15:0] n);
        cfg(3'd0, dm); cfg(3'd1, bb); cfg(3'd4, ab);
        cfg(3'd2, at[7:0]); cfg(3'd3, at[15:8]);
        cfg(3'd5, n[7:0]); cfg(3'd6, n[15:8]);
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Logs each CE period that has any strobe low, until DONE or the cycle budget runs out.
    task automatic collect(input bit dir);
        n_bytes = 0; n_cpurd = 0; n_cpuwr = 0; n_pard = 0; n_pawr = 0;
        n_data_bad = 0; n_done = 0; gap = 0; got_done = 0;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            @(negedge clk);
            bus.A_DI = 8'($urandom);
            bus.B_DI = 8'($urandom);
            #1;
            if (done) begin
                got_done = 1;
                n_done++;
            end else if (ce) begin
                if (!(bus.CPURD_N && bus.CPUWR_N && bus.PARD_N && bus.PAWR_N)) begin
                    if (n_bytes < 16) begin
                        ca_log[n_bytes] = bus.CA;
                        pa_log[n_bytes] = bus.PA;
                    end
                    n_bytes++;
                    gap = 0;
                    if (!bus.CPURD_N) n_cpurd++;
                    if (!bus.CPUWR_N) n_cpuwr++;
                    if (!bus.PARD_N)  n_pard++;
                    if (!bus.PAWR_N)  n_pawr++;
                    if (bus.D_OUT !== (dir ? bus.B_DI : bus.A_DI)) n_data_bad++;
                end else if (n_bytes > 0) begin
                    gap++;
                end
            end
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (done) n_done++;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.CA !== 24'd0) begin n_mis++; $display("FAIL reset_ca got=%h want=000000", bus.CA); end
        n_cmp++; if (bus.PA !== 8'hFF) begin n_mis++; $display("FAIL reset_pa got=%h want=ff", bus.PA); end
        n_cmp++; if ({bus.CPURD_N, bus.CPUWR_N, bus.PARD_N, bus.PAWR_N} !== 4'hF) begin
            n_mis++; $display("FAIL reset_strobes got=%b want=1111", {bus.CPURD_N, bus.CPUWR_N, bus.PARD_N, bus.PAWR_N}); end
        n_cmp++; if ({bus.D_OUT, busy, done} !== 10'd0) begin
            n_mis++; $display("FAIL reset_dout_busy_done got=%h/%b/%b want=00/0/0", bus.D_OUT, busy, done); end
        n_cmp++; if ({dut.dmap, dut.bbad, dut.a1b, dut.a1t, dut.das} !== 56'd0) begin
            n_mis++; $display("FAIL reset_regs got=%h want=0", {dut.dmap, dut.bbad, dut.a1b, dut.a1t, dut.das}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mode0;
        setup_xfer(8'h00, 8'h18, 8'h7E, 16'h1000, 16'd3);
        pulse_start;
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL m0_busy_after_start got=%b want=1", busy); end
        collect(1'b0);
        n_cmp++; if (n_bytes !== 3) begin n_mis++; $display("FAIL m0_bytes got=%0d want=3", n_bytes); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (ca_log[i] !== 24'h7E1000 + 24'(i)) begin
                n_mis++; $display("FAIL m0_ca[%0d] got=%h want=%h", i, ca_log[i], 24'h7E1000 + 24'(i)); end
            n_cmp++; if (pa_log[i] !== 8'h18) begin n_mis++; $display("FAIL m0_pa[%0d] got=%h want=18", i, pa_log[i]); end
        end
        n_cmp++; if ({n_cpurd, n_pawr, n_pard, n_cpuwr} !== {32'd3, 32'd3, 32'd0, 32'd0}) begin
            n_mis++; $display("FAIL m0_strobes got=%0d/%0d/%0d/%0d want=3/3/0/0", n_cpurd, n_pawr, n_pard, n_cpuwr); end
        n_cmp++; if (n_done !== 1) begin n_mis++; $display("FAIL m0_done_count got=%0d want=1", n_done); end
        n_cmp++; if (n_data_bad !== 0) begin n_mis++; $display("FAIL m0_dout got=%0d bad want=0", n_data_bad); end
        n_cmp++; if ({dut.a1t, dut.das} !== {16'h1003, 16'h0000}) begin
            n_mis++; $display("FAIL m0_final got=%h/%h want=1003/0000", dut.a1t, dut.das); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL m0_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_patterns;
        // mode 1, five bytes, FINISH right after the fifth
        setup_xfer(8'h01, 8'h18, 8'h7E, 16'h0000, 16'd5);
        pulse_start;
        collect(1'b0);
        exp_pa[0] = 8'h18; exp_pa[1] = 8'h19; exp_pa[2] = 8'h18; exp_pa[3] = 8'h19; exp_pa[4] = 8'h18;
        n_cmp++; if (n_bytes !== 5) begin n_mis++; $display("FAIL m1_bytes got=%0d want=5", n_bytes); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (pa_log[i] !== exp_pa[i]) begin n_mis++; $display("FAIL m1_pa[%0d] got=%h want=%h", i, pa_log[i], exp_pa[i]); end
        end
        n_cmp++; if (gap !== 1 || !got_done) begin n_mis++; $display("FAIL m1_finish_gap got=%0d done=%0d want=1/1", gap, got_done); end
        // mode 3 ends mid-pattern after six bytes
        setup_xfer(8'h03, 8'h10, 8'h7E, 16'h0000, 16'd6);
        pulse_start;
        collect(1'b0);
        exp_pa[0] = 8'h10; exp_pa[1] = 8'h10; exp_pa[2] = 8'h11; exp_pa[3] = 8'h11; exp_pa[4] = 8'h10; exp_pa[5] = 8'h10;
        n_cmp++; if (n_bytes !== 6) begin n_mis++; $display("FAIL m3_bytes got=%0d want=6", n_bytes); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (pa_log[i] !== exp_pa[i]) begin n_mis++; $display("FAIL m3_pa[%0d] got=%h want=%h", i, pa_log[i], exp_pa[i]); end
        end
        // mode 6 aliases mode 2
        setup_xfer(8'h06, 8'h20, 8'h7E, 16'h0000, 16'd3);
        pulse_start;
        collect(1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (pa_log[i] !== 8'h20) begin n_mis++; $display("FAIL m6_pa[%0d] got=%h want=20", i, pa_log[i]); end
        end
        // mode 5 aliases mode 1
        setup_xfer(8'h05, 8'h40, 8'h7E, 16'h0000, 16'd3);
        pulse_start;
        collect(1'b0);
        exp_pa[0] = 8'h40; exp_pa[1] = 8'h41; exp_pa[2] = 8'h40;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (pa_log[i] !== exp_pa[i]) begin n_mis++; $display("FAIL m5_pa[%0d] got=%h want=%h", i, pa_log[i], exp_pa[i]); end
        end
    endtask

    task automatic test_mode4_b2a;
        setup_xfer(8'h8C, 8'h80, 8'h00, 16'h0000, 16'd4);
        pulse_start;
        collect(1'b1);
        n_cmp++; if (n_bytes !== 4) begin n_mis++; $display("FAIL m4_bytes got=%0d want=4", n_bytes); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (pa_log[i] !== 8'h80 + 8'(i)) begin n_mis++; $display("FAIL m4_pa[%0d] got=%h want=%h", i, pa_log[i], 8'h80 + 8'(i)); end
            n_cmp++; if (ca_log[i] !== 24'h000000) begin n_mis++; $display("FAIL m4_ca[%0d] got=%h want=000000", i, ca_log[i]); end
        end
`ifdef BBUS_DMA_WRAM_GUARD_EN
        n_cmp++; if ({n_pard, n_cpuwr, n_cpurd, n_pawr} !== {32'd4, 32'd3, 32'd0, 32'd0}) begin
            n_mis++; $display("FAIL m4_strobes got=%0d/%0d/%0d/%0d want=4/3/0/0", n_pard, n_cpuwr, n_cpurd, n_pawr); end
`else
        n_cmp++; if ({n_pard, n_cpuwr, n_cpurd, n_pawr} !== {32'd4, 32'd4, 32'd0, 32'd0}) begin
            n_mis++; $display("FAIL m4_strobes got=%0d/%0d/%0d/%0d want=4/4/0/0", n_pard, n_cpuwr, n_cpurd, n_pawr); end
`endif
        n_cmp++; if (n_data_bad !== 0) begin n_mis++; $display("FAIL m4_dout got=%0d bad want=0", n_data_bad); end
        n_cmp++; if (dut.a1t !== 16'h0000) begin n_mis++; $display("FAIL m4_a1t_fixed got=%h want=0000", dut.a1t); end
    endtask

    task automatic test_wrap;
        setup_xfer(8'h10, 8'h18, 8'h01, 16'hFFFF, 16'd2);
        pulse_start;
        collect(1'b0);
        n_cmp++; if ({ca_log[0], ca_log[1]} !== {24'h01FFFF, 24'h01FFFE}) begin
            n_mis++; $display("FAIL dec_ca got=%h,%h want=01ffff,01fffe", ca_log[0], ca_log[1]); end
        setup_xfer(8'h00, 8'h18, 8'h01, 16'hFFFF, 16'd2);
        pulse_start;
        collect(1'b0);
        n_cmp++; if ({ca_log[0], ca_log[1]} !== {24'h01FFFF, 24'h010000}) begin
            n_mis++; $display("FAIL inc_ca got=%h,%h want=01ffff,010000", ca_log[0], ca_log[1]); end
        n_cmp++; if ({dut.a1b, dut.a1t} !== 24'h010001) begin
            n_mis++; $display("FAIL inc_final got=%h%h want=010001", dut.a1b, dut.a1t); end
    endtask

    task automatic test_reset_mid;
        bit seen;
        int lows;
        setup_xfer(8'h00, 8'h18, 8'h7E, 16'h2000, 16'd100);
        pulse_start;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk); #1;
            if (!bus.CPURD_N) seen = 1;
        end
        n_cmp++; if (!seen) begin n_mis++; $display("FAIL mid_xfer_start got=0 want=1"); end
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.CPURD_N, bus.PAWR_N, busy, bus.PA} !== {3'b110, 8'hFF}) begin
            n_mis++; $display("FAIL mid_reset got=%b%b%b/%h want=110/ff", bus.CPURD_N, bus.PAWR_N, busy, bus.PA); end
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (!(bus.CPURD_N && bus.CPUWR_N && bus.PARD_N && bus.PAWR_N) || busy || done) lows++;
        end
        n_cmp++; if (lows !== 0) begin n_mis++; $display("FAIL post_reset_activity got=%0d want=0", lows); end
        // config writes and a second START while busy must be ignored
        setup_xfer(8'h00, 8'h18, 8'h7E, 16'h3000, 16'd3);
        pulse_start;
        @(negedge clk); start = 1'b1; cfg_we = 1'b1; cfg_a = 3'd1; cfg_d = 8'h55;
        @(negedge clk); start = 1'b0; cfg_a = 3'd5; cfg_d = 8'h09;
        @(negedge clk); cfg_we = 1'b0;
        collect(1'b0);
        n_cmp++; if (n_bytes !== 3) begin n_mis++; $display("FAIL busy_cfg_bytes got=%0d want=3", n_bytes); end
        n_cmp++; if ({ca_log[0], pa_log[0], pa_log[2]} !== {24'h7E3000, 8'h18, 8'h18}) begin
            n_mis++; $display("FAIL busy_cfg_addr got=%h/%h/%h want=7e3000/18/18", ca_log[0], pa_log[0], pa_log[2]); end
        n_cmp++; if (dut.bbad !== 8'h18) begin n_mis++; $display("FAIL busy_cfg_bbad got=%h want=18", dut.bbad); end
        lows = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            if (busy) lows++;
        end
        n_cmp++; if (lows !== 0) begin n_mis++; $display("FAIL busy_start_ignored got=%0d want=0", lows); end
    endtask

    task automatic test_guard;
        setup_xfer(8'h00, 8'h80, 8'h7E, 16'h0000, 16'd2);
        pulse_start;
        collect(1'b0);
        n_cmp++; if (n_cpurd !== 2) begin n_mis++; $display("FAIL guard_cpurd got=%0d want=2", n_cpurd); end
`ifdef BBUS_DMA_WRAM_GUARD_EN
        n_cmp++; if (n_pawr !== 0) begin n_mis++; $display("FAIL guard_pawr got=%0d want=0", n_pawr); end
        n_cmp++; if (dut.a1t !== 16'h0002) begin n_mis++; $display("FAIL guard_a1t got=%h want=0002", dut.a1t); end
`else
        n_cmp++; if (n_pawr !== 2) begin n_mis++; $display("FAIL guard_pawr got=%0d want=2", n_pawr); end
`endif
    endtask

    initial begin
        bus.A_DI = 8'h00;
        bus.B_DI = 8'h00;
        test_reset;
        test_mode0;
        test_patterns;
        test_mode4_b2a;
        test_wrap;
        test_reset_mid;
        test_guard;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
